hazard_unit_mc: RTL
===================

# hazard_unit_mc

Parametrised successor to the pipeline hazard unit for the five-stage RISC-V core. It adds a multi-cycle execute path (mul/div) with an internal latency FSM, an execute-stage stall and memory-stage bubble, explicit priority between all hazard sources, and saturating stall/flush performance counters. It keeps the existing forwarding and load-use behaviour. It sits beside the datapath and controller in the core top level and drives all pipeline-register enables and clears.

## Interface
- MD_LAT, 4, cycles a multi-cycle op occupies E (≥1)
- RA_W, 5, register address width
- CNT_W, 16, performance counter width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- A1, A2  in  RA_W  source registers in D
- Rs1E, Rs2E, RdE  in  RA_W  source/destination registers in E
- RdM, RdW  in  RA_W  destination registers in M and W
- ResultSrcE  in  2  result select in E; 2'b01 = load
- RegWriteM, RegWriteW  in  1  write enables in M and W
- PCSrcE  in  2  nonzero = redirect taken in E
- MdE  in  1  E holds a multi-cycle op
- StallF, StallD, StallE  out  1  hold the F, D and E registers
- FlushD, FlushE, FlushM  out  1  clear the D, E and M registers to a bubble
- ForwardAE, ForwardBE  out  2  00 = register file, 10 = from M, 01 = from W
- MdDoneE  out  1  multi-cycle result valid in E this cycle
- StallCnt, FlushCnt  out  CNT_W  saturating counters

## Operation
- **Forwarding (combinational).** Per operand X in {Rs1E, Rs2E}:
  - 10 if RegWriteM && RdM==X && X!=0;
  - else 01 if RegWriteW && RdW==X && X!=0;
  - else 00.
  - M has priority over W. Register x0 is never forwarded.
- **Load-use.** lwStall = (ResultSrcE==01) && RdE!=0 && (A1==RdE || A2==RdE).
- **MD FSM.** States IDLE and BUSY; down-counter cnt of width clog2(MD_LAT).
  - **IDLE, MdE=1, MD_LAT>1:** mdStall=1. Next state BUSY, cnt←MD_LAT-2.
  - **IDLE, MdE=1, MD_LAT==1:** MdDoneE=1, no stall.
  - **BUSY, cnt!=0:** mdStall=1, cnt←cnt-1.
  - **BUSY, cnt==0:** MdDoneE=1, mdStall=0, next state IDLE.
  - Total occupancy in E is MD_LAT cycles, of which MD_LAT-1 are stall cycles.
- **Output priority** (highest first):
  - **mdStall:** StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0. PCSrcE and lwStall are ignored; neither can legally occur with a multi-cycle op in E.
  - **PCSrcE!=0:** FlushD=FlushE=1. StallF=StallD=0, even if lwStall is set, because the D instruction is discarded.
  - **lwStall:** StallF=StallD=1, FlushE=1.
  - **Otherwise:** all stall/flush outputs are 0.
- **Back-to-back MD ops.** Allowed. The FSM returns to IDLE after the done cycle, so the next op in E restarts the sequence the following cycle.
- **Counters.**
  - StallCnt increments on every cycle with StallF=1.
  - FlushCnt increments on every cycle with FlushD=1 (a taken redirect).
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding, stall, flush and MdDoneE outputs are combinational from the inputs and the FSM state, valid in the same cycle.
- FSM state, cnt and both counters update on the rising edge of clk.
- **Reset values:** state IDLE, cnt 0, StallCnt 0, FlushCnt 0.
- **Outputs with rst held and all inputs 0:** all stall/flush outputs 0, Forward* 00, MdDoneE 0.
- **rst asserted mid-BUSY:** FSM returns to IDLE at the next edge. Any partial MD operation is abandoned, and no MdDoneE pulse is produced for it.
- **MD latency:** an op entering E at cycle t gives MdDoneE=1 at cycle t+MD_LAT-1. The D-stage instruction advances into E at cycle t+MD_LAT.
- Redirect costs 2 flushed cycles, and a load-use stall costs 1 cycle, as in the previous generation.

## Test plan
- **Forwarding priority:** RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. With RegWriteM=0 → 01. With Rs1E=0 → 00.
- **Load-use:** ResultSrcE=01, RdE=7, A2=7 for 1 cycle → StallF=StallD=FlushE=1 for that cycle, StallCnt +1. With RdE=0 → no stall.
- **MD, MD_LAT=4:** MdE=1 from cycle 0.
  - Cycles 0–2: StallF/StallD/StallE/FlushM=1.
  - Cycle 3: MdDoneE=1, no stall.
  - StallCnt=3.
  - Repeat with MD_LAT=1 → MdDoneE=1 in cycle 0, no stall.
- **Simultaneous events:** PCSrcE=01 together with lwStall (ResultSrcE=01, RdE=A1=3) → FlushD=FlushE=1, StallF=StallD=0, FlushCnt +1.
- **Reset mid-operation:** MD_LAT=8, MdE=1, rst asserted in cycle 3 → state IDLE next cycle, no MdDoneE, counters 0.
- **Saturation:** CNT_W=4, hold lwStall for 20 cycles → StallCnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Purpose: hazard control for the five-stage core: forwarding, load-use, multi-cycle E stall, redirect flush, perf counters.
// Latency: forwarding/stall/flush/MdDoneE are combinational from inputs and FSM state; FSM and counters update on clk.
// Backpressure: a multi-cycle op holds F/D/E for MD_LAT-1 cycles and bubbles M; load-use holds F/D for one cycle.
module hazard_unit_mc #(
  parameter int MD_LAT = 4,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  A1,
  input  logic [RA_W-1:0]  A2,
  input  logic [RA_W-1:0]  Rs1E,
  input  logic [RA_W-1:0]  Rs2E,
  input  logic [RA_W-1:0]  RdE,
  input  logic [RA_W-1:0]  RdM,
  input  logic [RA_W-1:0]  RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       PCSrcE,
  input  logic             MdE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdDoneE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Down-counter must hold MD_LAT-2; keep at least one bit so MD_LAT==1 still elaborates.
  localparam int MD_CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [MD_CNT_W-1:0] MD_CNT_LOAD = MD_CNT_W'((MD_LAT > 1) ? (MD_LAT - 2) : 0);
  localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;

  logic md_stall;
  logic md_done;
  logic lw_stall;
  logic redirect;

  // Pick the youngest in-flight producer; M wins over W, x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [RA_W-1:0] src,
    input logic            wr_m,
    input logic [RA_W-1:0] rd_m,
    input logic            wr_w,
    input logic [RA_W-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (wr_m && (rd_m == src)) begin
        sel = 2'b10;
      end else if (wr_w && (rd_w == src)) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Operand forwarding selects for both E-stage sources.
  always_comb begin
    ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
  end

  // Load in E whose destination is read by the D-stage instruction.
  always_comb begin
    lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) && ((A1 == RdE) || (A2 == RdE));
    redirect = (PCSrcE != 2'b00);
  end

  // Multi-cycle execute sequencer: stall until the last occupancy cycle, then pulse done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (MdE) begin
          if (MD_LAT > 1) begin
            md_stall = 1'b1;
            state_d  = MD_BUSY;
            cnt_d    = MD_CNT_LOAD;
          end else begin
            md_done = 1'b1;
          end
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0) begin
          md_stall = 1'b1;
          cnt_d    = cnt_q - MD_CNT_W'(1);
        end else begin
          md_done = 1'b1;
          state_d = MD_IDLE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Resolve hazard sources into pipeline-register controls, highest priority first.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    MdDoneE = md_done;
    if (md_stall) begin
      // Redirects and load-use cannot coexist with a multi-cycle op in E.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (redirect) begin
      // D is being discarded, so a pending load-use stall on it is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // Saturating performance counters for fetch stalls and redirect flushes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (FlushD && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

  // State and counter registers; reset abandons any in-flight multi-cycle op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
